// File: rtl/seq_alu_pkg.sv
// Shared types and op decode helpers for seq_alu.
// SEQ_ALU_MUL_EN enables the shift-add multiply (op 9); without it op 9 decodes as illegal.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SAR = 4'd7,
    OP_CMP = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } alu_state_e;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef SEQ_ALU_MUL_EN
    return op < OP_ILLEGAL_MIN;
`else
    return (op < OP_ILLEGAL_MIN) && (op != OP_MUL);
`endif
  endfunction

  function automatic logic op_is_shift(input alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Final-step flag derivation: zero/sign from the computed value, carry/overflow
// selected from the per-op candidates according to the operation.
module alu_flag_gen
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e            op_i,
  input  logic [WIDTH-1:0]   value_i,
  input  logic               add_carry_i,
  input  logic               add_ovf_i,
  input  logic               sub_borrow_i,
  input  logic               sub_ovf_i,
  input  logic               shift_carry_i,
  input  logic               mul_ovf_i,
  output logic               zero_o,
  output logic               sign_o,
  output logic               carry_o,
  output logic               overflow_o
);

  always_comb begin
    zero_o     = (value_i == '0);
    sign_o     = value_i[WIDTH-1];
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        carry_o    = add_carry_i;
        overflow_o = add_ovf_i;
      end
      OP_SUB, OP_CMP: begin
        carry_o    = sub_borrow_i;
        overflow_o = sub_ovf_i;
      end
      OP_SHL, OP_SHR, OP_SAR: carry_o = shift_carry_i;
      OP_MUL: begin
        carry_o    = mul_ovf_i;
        overflow_o = mul_ovf_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the status register: one op per start/done handshake.
// Optional multiply under SEQ_ALU_MUL_EN (one partial-product step per cycle).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             flag_we,
  output logic [WIDTH-1:0] result,
  output logic             zero_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             sign_out,
  output alu_state_e       dbg_state
);

  // Handshake: start is only sampled in IDLE; done/flag_we are single-cycle
  // pulses in the cycle after the final EXEC step, when the FSM is IDLE again.

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  alu_state_e       state_q;
  alu_op_e          op_q;
  logic             legal_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, flag_we_q;
  logic             zero_q, carry_q, ovf_q, sign_q;

  logic [WIDTH:0]   sum_w, diff_w;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] sh_next, value_d;
  logic             sh_out, shift_carry, last_step, iterate;
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_lo;
  logic             fz, fs, fc, fv;

  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w  = {1'b0, a_q} - {1'b0, b_q};
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    sh_next = a_q;
    sh_out  = 1'b0;
    case (op_q)
      OP_SHL: begin
        sh_next = {a_q[WIDTH-2:0], 1'b0};
        sh_out  = a_q[WIDTH-1];
      end
      OP_SHR: begin
        sh_next = {1'b0, a_q[WIDTH-1:1]};
        sh_out  = a_q[0];
      end
      OP_SAR: begin
        sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        sh_out  = a_q[0];
      end
      default: ;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // prod_q = {accumulator, remaining multiplier bits}; each step adds a on the
  // multiplier LSB and shifts the whole pair right by one.
  logic [2*WIDTH-1:0] prod_q, mul_next;
  logic [WIDTH:0]     mul_sum;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_ovf  = |mul_next[2*WIDTH-1:WIDTH];
  assign mul_lo   = mul_next[WIDTH-1:0];
`else
  assign mul_ovf  = 1'b0;
  assign mul_lo   = '0;
`endif

  assign shift_carry = (cnt_q != '0) && sh_out;
  assign last_step   = (cnt_q <= CW'(1));
  assign iterate     = legal_q && !last_step && (op_is_shift(op_q) || op_q == OP_MUL);

  always_comb begin
    cnt_d = '0;
    if (op_is_shift(alu_op_e'(op)))
      cnt_d = {{(CW-SW){1'b0}}, b[SW-1:0]};
    else if (op == OP_MUL)
      cnt_d = CW'(WIDTH);
  end

  always_comb begin
    value_d = '0;
    case (op_q)
      OP_ADD:                 value_d = sum_w[WIDTH-1:0];
      OP_SUB, OP_CMP:         value_d = diff_w[WIDTH-1:0];
      OP_AND:                 value_d = a_q & b_q;
      OP_OR:                  value_d = a_q | b_q;
      OP_XOR:                 value_d = a_q ^ b_q;
      OP_SHL, OP_SHR, OP_SAR: value_d = (cnt_q == '0) ? a_q : sh_next;
      OP_MUL:                 value_d = mul_lo;
      default: ;
    endcase
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op_i          (op_q),
    .value_i       (value_d),
    .add_carry_i   (sum_w[WIDTH]),
    .add_ovf_i     (add_ovf),
    .sub_borrow_i  (diff_w[WIDTH]),
    .sub_ovf_i     (sub_ovf),
    .shift_carry_i (shift_carry),
    .mul_ovf_i     (mul_ovf),
    .zero_o        (fz),
    .sign_o        (fs),
    .carry_o       (fc),
    .overflow_o    (fv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      legal_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      flag_we_q <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sign_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      prod_q    <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      flag_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= alu_op_e'(op);
            legal_q <= op_is_legal(op);
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= cnt_d;
`ifdef SEQ_ALU_MUL_EN
            prod_q  <= {{WIDTH{1'b0}}, b};
`endif
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (iterate) begin
            if (op_is_shift(op_q)) a_q <= sh_next;
            cnt_q <= cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
            prod_q <= mul_next;
`endif
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
            if (legal_q) begin
              flag_we_q <= 1'b1;
              zero_q    <= fz;
              sign_q    <= fs;
              carry_q   <= fc;
              ovf_q     <= fv;
              if (op_q != OP_CMP) result_q <= value_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_q == ST_EXEC);
  assign done         = done_q;
  assign flag_we      = flag_we_q;
  assign result       = result_q;
  assign zero_out     = zero_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign sign_out     = sign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH = 8); follows SEQ_ALU_MUL_EN for op 9 expectations.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, flag_we;
  logic [W-1:0] result;
  logic         zero_out, carry_out, overflow_out, sign_out;
  alu_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  // Architectural state the status register would see.
  logic [W-1:0] m_result;
  bit           m_z, m_c, m_v, m_s;
  logic [W-1:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .flag_we(flag_we), .result(result),
    .zero_out(zero_out), .carry_out(carry_out), .overflow_out(overflow_out),
    .sign_out(sign_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: arithmetic on plain ints, updates the expected architectural state.
  task automatic model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output bit we);
    int ux, uy, sx, sy, n, full, r;
    bit c, v, wr;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    n = uy % 8;
    full = 0; c = 0; v = 0; wr = 1; lat = 1; we = 1;
    case (o)
      4'd0: begin full = ux + uy; c = full > 255; v = (sx + sy > 127) || (sx + sy < -128); end
      4'd1, 4'd8: begin
        full = ux - uy; c = ux < uy; v = (sx - sy > 127) || (sx - sy < -128); wr = (o == 4'd1);
      end
      4'd2: full = ux & uy;
      4'd3: full = ux | uy;
      4'd4: full = ux ^ uy;
      4'd5: begin full = ux << n; c = (n > 0) && (((ux >> (8 - n)) & 1) == 1); lat = (n > 0) ? n : 1; end
      4'd6: begin full = ux >> n; c = (n > 0) && (((ux >> (n - 1)) & 1) == 1); lat = (n > 0) ? n : 1; end
      4'd7: begin full = sx >>> n; c = (n > 0) && (((sx >>> (n - 1)) & 1) == 1); lat = (n > 0) ? n : 1; end
`ifdef SEQ_ALU_MUL_EN
      4'd9: begin full = ux * uy; c = full > 255; v = c; lat = 8; end
`endif
      default: we = 0;
    endcase
    r = full & 255;
    if (we) begin
      m_z = (r == 0);
      m_s = r[7];
      m_c = c;
      m_v = v;
      if (wr) m_result = r[7:0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, flag_we, result, zero_out, carry_out, overflow_out, sign_out} !== '0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b we=%b res=%h z%b c%b v%b s%b st=%0d required all zero/IDLE",
               busy, done, flag_we, result, zero_out, carry_out, overflow_out, sign_out, dbg_state);
    end
    reset = 1'b0;
    m_result = '0; m_z = 0; m_c = 0; m_v = 0; m_s = 0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int lat, j;
    bit we;
    model(o, x, y, lat, we);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start op=%0d: got %b required 1", o, busy);
    end
    j = 0;
    do begin @(negedge clk); j++; end while (done !== 1'b1 && j < 40);
    checks++;
    if (j != lat || done !== 1'b1) begin
      errors++; $display("FAIL latency op=%0d a=%h b=%h: got %0d (done=%b) required %0d", o, x, y, j, done, lat);
    end
    checks++;
    if (flag_we !== we) begin
      errors++; $display("FAIL flag_we op=%0d: got %b required %b", o, flag_we, we);
    end
    checks++;
    if ({result, zero_out, carry_out, overflow_out, sign_out} !== {m_result, m_z, m_c, m_v, m_s}) begin
      errors++;
      $display("FAIL outputs op=%0d a=%h b=%h: got res=%h z%b c%b v%b s%b required res=%h z%b c%b v%b s%b",
               o, x, y, result, zero_out, carry_out, overflow_out, sign_out, m_result, m_z, m_c, m_v, m_s);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_on_done op=%0d: got %b required 0", o, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || flag_we !== 1'b0) begin
      errors++; $display("FAIL pulse_width op=%0d: done=%b we=%b required 0 0", o, done, flag_we);
    end
  endtask

  task automatic test_directed();
    run_op(4'd0, 8'h7F, 8'h01);
    run_op(4'd1, 8'h05, 8'h05);
    run_op(4'd8, 8'h03, 8'h05);
    run_op(4'd5, 8'h81, 8'h03);
    run_op(4'd6, 8'h81, 8'h01);
    run_op(4'd7, 8'h80, 8'h00);
    run_op(4'd9, 8'h10, 8'h10);
    run_op(4'd12, 8'h55, 8'hAA);
    run_op(4'd7, 8'h96, 8'h07);
    run_op(4'd15, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) o = 4'($urandom_range(0, 9));
      run_op(o, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_start_ignored();
    int lat, n_done, first;
    bit we;
    logic [7:0] x;
    x = 8'($urandom_range(1, 255));
    n_done = 0; first = -1;
    model(4'd5, x, 8'hF7, lat, we);
    @(negedge clk); start = 1'b1; op = 4'd5; a = x; b = 8'hF7;
    @(negedge clk); start = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      if (j == 3) begin start = 1'b1; op = 4'd0; a = 8'($urandom); b = 8'($urandom); end
      else start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) begin
          first = j;
          checks++;
          if ({result, zero_out, carry_out, overflow_out, sign_out} !== {m_result, m_z, m_c, m_v, m_s}) begin
            errors++;
            $display("FAIL ignored_start_outputs: got res=%h c%b required res=%h c%b", result, carry_out, m_result, m_c);
          end
        end
      end
    end
    checks++;
    if (n_done != 1 || first != lat) begin
      errors++; $display("FAIL ignored_start_dones: got %0d dones first at %0d required 1 at %0d", n_done, first, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit we;
    logic [7:0] x1, y1, x2, y2;
    x1 = 8'($urandom); y1 = 8'($urandom); x2 = 8'($urandom); y2 = 8'($urandom);
    model(4'd0, x1, y1, lat, we); exp_q.push_back(m_result);
    model(4'd1, x2, y2, lat, we); exp_q.push_back(m_result);
    @(negedge clk); start = 1'b1; op = 4'd0; a = x1; b = y1;
    @(negedge clk); op = 4'd1; a = x2; b = y2;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== exp_q[0]) begin
      errors++; $display("FAIL b2b_first: done=%b res=%h required 1 %h", done, result, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || {result, zero_out, carry_out, overflow_out, sign_out} !==
        {exp_q[0], m_z, m_c, m_v, m_s}) begin
      errors++;
      $display("FAIL b2b_second: done=%b res=%h z%b c%b v%b s%b required 1 %h z%b c%b v%b s%b",
               done, result, zero_out, carry_out, overflow_out, sign_out, exp_q[0], m_z, m_c, m_v, m_s);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    run_op(4'd0, 8'h7F, 8'h01);
    @(negedge clk); start = 1'b1; a = 8'($urandom_range(1, 255)); b = 8'hFF;
`ifdef SEQ_ALU_MUL_EN
    op = 4'd9;
`else
    op = 4'd5;
`endif
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m_result = '0; m_z = 0; m_c = 0; m_v = 0; m_s = 0;
    checks++;
    if ({busy, done, flag_we, result, zero_out, carry_out, overflow_out, sign_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b we=%b res=%h z%b c%b v%b s%b required all zero",
               busy, done, flag_we, result, zero_out, carry_out, overflow_out, sign_out);
    end
    n_done = 0;
    repeat (12) begin @(negedge clk); if (done === 1'b1) n_done++; end
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL aborted_done: got %0d dones required 0", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle ALU that sits directly upstream of the processor status register. It accepts one operation per start/done handshake and runs add/subtract/logic in one cycle, shifts at one bit per cycle, and an optional shift-add multiply. It drives a registered result and zero/carry/overflow/sign flags with a one-cycle flag write strobe. Flag outputs hold stable between operations, so the status register may capture them every cycle.

## Interface
- `WIDTH`, default 8: operand and result width, at least 4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 4: operation code.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B; for shifts, shift amount is `b[$clog2(WIDTH)-1:0]`.
- `busy` out 1: high while in EXEC.
- `done` out 1: one-cycle completion pulse.
- `flag_we` out 1: one-cycle pulse; flags were updated this completion.
- `result` out WIDTH: registered result.
- `zero_out`, `carry_out`, `overflow_out`, `sign_out` out 1 each: registered flags feeding the status register.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 SAR (arithmetic), 8 CMP (SUB without result write), 9 MUL. Codes 10–15 are illegal.
- FSM has two states:
  - IDLE, when `start` is high: latch `op`, `a`, `b` and the shift count, then go to EXEC.
  - EXEC: iterate; on the final step, update outputs, pulse `done`, and return to IDLE.
- Flags:
  - `zero_out` = computed value == 0.
  - `sign_out` = computed value MSB. For CMP, both use the difference.
  - ADD: `carry_out` = unsigned carry-out; `overflow_out` = signed overflow.
  - SUB and CMP: `carry_out` = borrow (a < b unsigned); `overflow_out` = signed overflow.
  - AND, OR, XOR: `carry_out` = 0, `overflow_out` = 0.
  - Shifts: `carry_out` = last bit shifted out (0 if the count is 0); `overflow_out` = 0.
  - MUL: `result` = low WIDTH bits of the unsigned product; `carry_out` = `overflow_out` = upper WIDTH bits nonzero.
- CMP updates flags and asserts `flag_we`; `result` holds its previous value.
- Illegal op: takes one cycle; `done` pulses, `flag_we` = 0, and `result` and flags are unchanged.
- `start` while in EXEC is ignored; it is not queued.

## Timing
- `start` sampled at edge k. Outputs update and `done`/`flag_we` go high after edge k+L, for exactly one cycle.
  - L = 1 for ADD, SUB, logic ops, CMP, illegal ops, and shifts with count 0.
  - L = n for shifts with count n ≥ 1.
  - L = WIDTH for MUL.
- `busy` is high from after edge k through edge k+L.
- Back-to-back: the FSM is in IDLE during the `done` cycle, so a `start` sampled then is accepted, giving one op per L+1 cycles.
- Reset (any cycle, including mid-EXEC):
  - FSM returns to IDLE and the operation is aborted without a `done`.
  - `busy`, `done`, `flag_we` = 0; `result` = 0; all four flags = 0.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL is implemented as above, one partial-product step per cycle, WIDTH cycles.
- `SEQ_ALU_MUL_EN` undefined: op 9 is treated as illegal (one cycle, `flag_we` = 0), and no multiplier datapath or product register is synthesised.

## Structure
- `seq_alu_pkg` holds:
  - the `alu_op_e` enum (4-bit op codes above);
  - the `alu_state_e` enum (IDLE, EXEC);
  - the `OP_ILLEGAL_MIN` = 10 constant.
- One natural sub-module, `alu_flag_gen`: combinational, derives zero and sign from a WIDTH value plus the op-specific carry/overflow selection, used at the final step.

## Test plan
- ADD a=0x7F, b=0x01 → one cycle after start: `result` = 0x80, `sign_out` = 1, `overflow_out` = 1, `carry_out` = 0, `zero_out` = 0, with `done` and `flag_we` pulsed once.
- SUB 0x05−0x05 → `result` = 0x00, `zero_out` = 1, `carry_out` = 0. Then CMP 0x03,0x05 → `carry_out` = 1, `sign_out` = 1, `result` still 0x00.
- SHL 0x81 by 3 → `done` 3 cycles after start, `result` = 0x08, `carry_out` = 0. SHR 0x81 by 1 → 0x40, `carry_out` = 1. SAR 0x80 by 0 → 1 cycle, 0x80, `carry_out` = 0.
- MUL 0x10×0x10 with the macro → `done` after 8 cycles, `result` = 0x00, `carry_out` = `overflow_out` = `zero_out` = 1. Without the macro → `done` after 1 cycle, `flag_we` = 0, outputs unchanged.
- `start` pulsed during a MUL is ignored (exactly one `done`). A `start` held high on the `done` cycle begins the next op immediately.
- Reset asserted at cycle 4 of a MUL → next cycle: `busy` = 0, `result` = 0, all flags 0, and no `done` ever pulses for the aborted op.
